pico_io_sequencer: RTL and testbench
====================================

PICO_IO_SEQUENCER -- requirements
Module: pico_io_sequencer

Interface
REQ-001 Parameter N, default 8: data width of in_bus, operands, result and out_bus.
REQ-002 Parameter DebounceCycles, default 4: cycles a synchronised switch level must stay stable before it is accepted.
REQ-003 Parameter MaxRunCycles, default 64: processor run budget in cycles before timeout.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_bus  input  N  raw switch data operand.
REQ-007 io_handshake  input  1  raw asynchronous push-button level.
REQ-008 proc_done  input  1  processor completion strobe.
REQ-009 proc_result  input  N  processor result, valid while proc_done=1.
REQ-010 op_a  output  N  captured first operand.
REQ-011 op_b  output  N  captured second operand.
REQ-012 start  output  1  one-cycle processor start pulse.
REQ-013 out_bus  output  N  displayed result.
REQ-014 result_valid  output  1  high while a fresh result is shown.
REQ-015 err  output  1  high while in timeout error state.

Function
REQ-016 io_handshake SHALL pass a 2-flop synchroniser, then a debouncer: the accepted level changes only after the synchronised level differs from it for DebounceCycles consecutive cycles; any bounce restarts the count.
REQ-017 A press event SHALL be a single-cycle 0->1 transition of the accepted level; a release event a single-cycle 1->0 transition.
REQ-018 States: WAIT_A, HOLD_A, WAIT_B, HOLD_B, RUN, SHOW, ACK, ERR.
REQ-019 WAIT_A: on press, op_a <= in_bus sampled that cycle; go HOLD_A.
REQ-020 HOLD_A: on release go WAIT_B; in_bus changes SHALL NOT affect op_a.
REQ-021 WAIT_B: on press, op_b <= in_bus sampled that cycle; go HOLD_B.
REQ-022 HOLD_B: on release go RUN; start SHALL be 1 for exactly the first cycle in RUN, 0 otherwise.
REQ-023 RUN: run counter cleared on entry, +1 per cycle; proc_done SHALL be ignored in the start cycle; first later cycle with proc_done=1 -> out_bus <= proc_result, result_valid <= 1, go SHOW.
REQ-024 RUN: if counter reaches MaxRunCycles without accepted proc_done -> out_bus <= all ones, err <= 1, go ERR; proc_done in that same cycle takes priority over timeout.
REQ-025 RUN: press/release events SHALL be ignored.
REQ-026 SHOW: on press go ACK; ACK: on release go WAIT_A, result_valid <= 0, out_bus retained until the next result or error.
REQ-027 ERR: on press, err <= 0, go ACK.
REQ-028 op_a/op_b SHALL hold their values until recaptured; proc_done outside RUN SHALL be ignored.
REQ-029 Button held across reset deassertion SHALL NOT generate a press until released and pressed again (accepted level resets to 0, needs stable-high period).

Reset
REQ-030 When reset=1 at a clock edge: state WAIT_A, op_a=op_b=out_bus=0, start=result_valid=err=0, synchroniser flops, accepted level, debounce and run counters =0.
REQ-031 Reset asserted mid-operation (any state, including RUN with start high) SHALL take effect at that edge and abort the sequence; no start pulse after reset until a full A/B sequence completes.

Verification
REQ-032 Clean sequence: press with in_bus=8'hCE, release, press with 8'h8B, release, proc_done with proc_result=8'h59 3 cycles after start -> op_a=CE, op_b=8B, one start pulse, out_bus=59, result_valid=1.
REQ-033 Bounce: io_handshake toggling every 2 cycles for 10 cycles then stable high, DebounceCycles=4 -> exactly one press event, accepted 4 cycles after stability (+2 sync).
REQ-034 Timeout: full A/B sequence, proc_done never asserted, MaxRunCycles=64 -> after 64 RUN cycles out_bus=8'hFF, err=1; press/release returns WAIT_A, err=0.
REQ-035 Second run: after ACK, repeat with 8'h22 and 8'h55, result 8'h77 -> op_a=22, op_b=55, out_bus=77; stale result held at previous value until new proc_done.
REQ-036 Reset in RUN: assert reset one cycle after start -> all outputs 0 next edge, late proc_done ignored, out_bus stays 0.
REQ-037 Edge cases: in_bus changed during HOLD_A -> op_a unchanged; proc_done in start cycle -> ignored; button presses in RUN -> no state change.

Source files
------------

// File: rtl/pico_io_sequencer.sv
// pico_io_sequencer: collects two operands from switches via a debounced push
// button, starts an external processor, waits for its result (with a run
// budget), and displays the result until the user acknowledges it.
//
// state  | meaning
// -------+------------------------------------------------------------
// WAIT_A | idle, waiting for a press to capture operand A
// HOLD_A | operand A captured, waiting for button release
// WAIT_B | waiting for a press to capture operand B
// HOLD_B | operand B captured, release launches the processor
// RUN    | processor running; start pulse in first cycle, run budget counting
// SHOW   | fresh result displayed, waiting for press
// ACK    | acknowledged, waiting for release to return to WAIT_A
// ERR    | run budget exhausted, out_bus all ones, waiting for press
module pico_io_sequencer #(
    parameter int N              = 8,
    parameter int DebounceCycles = 4,
    parameter int MaxRunCycles   = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] in_bus,
    input  logic         io_handshake,
    input  logic         proc_done,
    input  logic [N-1:0] proc_result,
    output logic [N-1:0] op_a,
    output logic [N-1:0] op_b,
    output logic         start,
    output logic [N-1:0] out_bus,
    output logic         result_valid,
    output logic         err
);

    localparam int DW = $clog2(DebounceCycles + 1);
    localparam int RW = $clog2(MaxRunCycles + 1);

    typedef enum logic [2:0] {
        WAIT_A, HOLD_A, WAIT_B, HOLD_B, RUN, SHOW, ACK, ERR
    } state_t;

    state_t          state;
    logic            sync_1;
    logic            sync_2;
    logic            btn_level;
    logic            btn_level_d;
    logic [DW-1:0]   deb_cnt;
    logic [RW-1:0]   run_cnt;
    logic            press;
    logic            release_evt;

    // Two-flop synchroniser for the asynchronous push-button.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= io_handshake;
            sync_2 <= sync_1;
        end
    end

    // Debouncer: accept a new level only after it has differed for
    // DebounceCycles consecutive cycles; any return to the old level restarts.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_level   <= 1'b0;
            btn_level_d <= 1'b0;
            deb_cnt     <= '0;
        end else begin
            btn_level_d <= btn_level;
            if (sync_2 == btn_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DW'(DebounceCycles - 1)) begin
                btn_level <= sync_2;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    assign press       = btn_level & ~btn_level_d;
    assign release_evt = ~btn_level & btn_level_d;

    // Sequencing FSM with registered outputs; start is high only in the
    // first RUN cycle, which is also the cycle where proc_done is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= WAIT_A;
            op_a         <= '0;
            op_b         <= '0;
            out_bus      <= '0;
            start        <= 1'b0;
            result_valid <= 1'b0;
            err          <= 1'b0;
            run_cnt      <= '0;
        end else begin
            start <= 1'b0;
            case (state)
                WAIT_A: if (press) begin
                    op_a  <= in_bus;
                    state <= HOLD_A;
                end
                HOLD_A: if (release_evt) state <= WAIT_B;
                WAIT_B: if (press) begin
                    op_b  <= in_bus;
                    state <= HOLD_B;
                end
                HOLD_B: if (release_evt) begin
                    start   <= 1'b1;
                    run_cnt <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    if (!start && proc_done) begin
                        out_bus      <= proc_result;
                        result_valid <= 1'b1;
                        state        <= SHOW;
                    end else if (run_cnt == RW'(MaxRunCycles - 1)) begin
                        out_bus <= '1;
                        err     <= 1'b1;
                        state   <= ERR;
                    end else begin
                        run_cnt <= run_cnt + RW'(1);
                    end
                end
                SHOW: if (press) state <= ACK;
                ACK: if (release_evt) begin
                    result_valid <= 1'b0;
                    state        <= WAIT_A;
                end
                ERR: if (press) begin
                    err   <= 1'b0;
                    state <= ACK;
                end
                default: state <= WAIT_A;
            endcase
        end
    end

endmodule

// File: tb/tb_pico_io_sequencer.sv
// Directed bench for pico_io_sequencer with default parameters.
module tb_pico_io_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_bus;
    logic       io_handshake;
    logic       proc_done;
    logic [7:0] proc_result;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       start;
    logic [7:0] out_bus;
    logic       result_valid;
    logic       err;

    int tests  = 0;
    int failed = 0;
    int start_cnt = 0;
    int s0;

    pico_io_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .in_bus       (in_bus),
        .io_handshake (io_handshake),
        .proc_done    (proc_done),
        .proc_result  (proc_result),
        .op_a         (op_a),
        .op_b         (op_b),
        .start        (start),
        .out_bus      (out_bus),
        .result_valid (result_valid),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (start === 1'b1) start_cnt++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press_release(input logic [7:0] val);
        in_bus       = val;
        io_handshake = 1'b1;
        tick(10);
        io_handshake = 1'b0;
        tick(10);
    endtask

    // Returns positioned in the start cycle (or flags a timeout).
    task automatic wait_start();
        int n;
        n = 0;
        while (start !== 1'b1 && n < 30) begin
            tick(1);
            n++;
        end
        chk("start_seen", {31'd0, start}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; in_bus = 8'h00; io_handshake = 1'b0;
        proc_done = 1'b0; proc_result = 8'h00;
        tick(3);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        chk("rst_out", out_bus, 0);
        chk("rst_flags", {start, result_valid, err}, 0);
        reset = 1'b0;
        tick(2);

        // Clean sequence, in_bus change during HOLD_A, proc_done in start cycle.
        in_bus = 8'hCE; io_handshake = 1'b1;
        tick(10);
        chk("t1_op_a", op_a, 8'hCE);
        in_bus = 8'h33;
        tick(2);
        io_handshake = 1'b0;
        tick(10);
        chk("t1_op_a_hold", op_a, 8'hCE);
        in_bus = 8'h8B; io_handshake = 1'b1;
        tick(10);
        chk("t1_op_b", op_b, 8'h8B);
        s0 = start_cnt;
        io_handshake = 1'b0;
        wait_start();
        proc_done = 1'b1; proc_result = 8'hAA;
        tick(1);
        proc_done = 1'b0;
        chk("t1_done_in_start", {result_valid, out_bus}, 9'h000);
        tick(2);
        proc_done = 1'b1; proc_result = 8'h59;
        tick(1);
        proc_done = 1'b0;
        chk("t1_out", out_bus, 8'h59);
        chk("t1_valid", {result_valid, err}, 2'b10);
        chk("t1_start_pulses", start_cnt - s0, 1);
        io_handshake = 1'b1;
        tick(10);
        chk("t1_ack_valid", result_valid, 1);
        io_handshake = 1'b0;
        tick(10);
        chk("t1_back_valid", result_valid, 0);
        chk("t1_out_kept", out_bus, 8'h59);

        // Second run: stale result held until new proc_done.
        press_release(8'h22);
        in_bus = 8'h55; io_handshake = 1'b1;
        tick(10);
        io_handshake = 1'b0;
        wait_start();
        chk("t2_stale", {result_valid, out_bus}, {1'b0, 8'h59});
        tick(1);
        proc_done = 1'b1; proc_result = 8'h77;
        tick(1);
        proc_done = 1'b0;
        chk("t2_op_a", op_a, 8'h22);
        chk("t2_op_b", op_b, 8'h55);
        chk("t2_out", {result_valid, out_bus}, {1'b1, 8'h77});
        press_release(8'h00);
        proc_done = 1'b1; proc_result = 8'h11;
        tick(2);
        proc_done = 1'b0;
        chk("t2_done_idle", {result_valid, out_bus}, {1'b0, 8'h77});

        // Timeout, with button activity during RUN.
        press_release(8'h01);
        in_bus = 8'h02; io_handshake = 1'b1;
        tick(10);
        io_handshake = 1'b0;
        wait_start();
        io_handshake = 1'b1;
        tick(12);
        io_handshake = 1'b0;
        tick(12);
        chk("t3_run_press", {err, result_valid, out_bus}, {2'b00, 8'h77});
        tick(39);
        chk("t3_pre_timeout", {err, out_bus}, {1'b0, 8'h77});
        tick(1);
        chk("t3_timeout", {err, out_bus}, {1'b1, 8'hFF});
        io_handshake = 1'b1;
        tick(10);
        chk("t3_err_clear", err, 0);
        io_handshake = 1'b0;
        tick(10);

        // Reset one cycle after start.
        press_release(8'h44);
        in_bus = 8'h66; io_handshake = 1'b1;
        tick(10);
        s0 = start_cnt;
        io_handshake = 1'b0;
        wait_start();
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t4_rst_ops", {op_a, op_b}, 16'h0000);
        chk("t4_rst_out", {start, result_valid, err, out_bus}, 11'h000);
        proc_done = 1'b1; proc_result = 8'h99;
        tick(2);
        proc_done = 1'b0;
        tick(10);
        chk("t4_late_done", {result_valid, out_bus}, 9'h000);
        chk("t4_start_pulses", start_cnt - s0, 1);

        // Bounce: 2-cycle toggles never accepted; stable high accepted after 2+4.
        for (int i = 0; i < 10; i++) begin
            in_bus = 8'h10 + 8'(i);
            io_handshake = ((i / 2) % 2 == 1);
            tick(1);
        end
        in_bus = 8'h5A; io_handshake = 1'b1;
        tick(6);
        chk("t5_no_early_press", op_a, 8'h00);
        tick(1);
        chk("t5_press", op_a, 8'h5A);
        io_handshake = 1'b0;
        tick(10);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
